fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding and burst counter width.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int BCNT_W = 4;

endpackage : fifo_arb_pkg

// File: rtl/rr_pick.sv
// Round-robin search: first set request bit after 'last', wrapping. Purely combinational.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  int cand;

  // NOTE: every output of this block gets a default before the loop, so no path leaves a value held (no latch).
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of an async FIFO write port.
// Optional words-written counter enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [DSIZE-1:0]        wdata,
  output logic                    winc,
  input  logic                    wfull,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic [15:0]             stat_words
);

  localparam int IW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic              accept;
  logic [DSIZE-1:0]  owner_word;

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req  (req),
    .last (last_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    owner_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) owner_word = req_data[i*DSIZE +: DSIZE];
    end
  end

  assign accept  = (state_q == BURST) && req[owner_q] && !wfull;
  assign cnt_inc = cnt_q + BCNT_W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // A full FIFO stalls in place: the owner keeps the grant and nothing is counted.
        if (!req[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == BCNT_W'(MAX_BURST)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only registered state, so clearing state_q in reset kills winc in the same cycle.
  always_comb begin
    gnt   = '0;
    winc  = 1'b0;
    wdata = '0;
    if (state_q == BURST) begin
      wdata = owner_word;
      if (accept) begin
        winc         = 1'b1;
        gnt[owner_q] = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment and the asynchronous active-low reset.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign owner = owner_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (winc && stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) stat_q <= '0;
    else         stat_q <= stat_d;
  end

  assign stat_words = stat_q;
`else
  assign stat_words = 16'd0;
`endif

endmodule : fifo_wr_arbiter
